// File: rtl/node_port_if.sv
// Router-side link of the node port: the offer/ack handshake towards the router
// and the router's delivery path back to the node.
// master = node_port side, slave = router side.
interface node_port_if;
    logic [28:0] Packet_From_Node;
    logic        Packet_From_Node_Valid;
    logic        Core_Load_Ack;
    logic [23:0] Packet_To_Node;
    logic        Packet_To_Node_Valid;

    modport master (
        output Packet_From_Node,
        output Packet_From_Node_Valid,
        input  Core_Load_Ack,
        input  Packet_To_Node,
        input  Packet_To_Node_Valid
    );

    modport slave (
        input  Packet_From_Node,
        input  Packet_From_Node_Valid,
        output Core_Load_Ack,
        output Packet_To_Node,
        output Packet_To_Node_Valid
    );
endinterface

// File: rtl/node_port.sv
// node_port: node-side endpoint of the router's parallel node interface.
// The TX FIFO is filled by the core and drained by an IDLE/OFFER/GAP offer FSM.
// The RX FIFO captures router deliveries and is drained by the core (show-ahead).
// Optional macro NODE_PORT_SELF_LOOP_EN: packets addressed to this node
// (dest == r_addr, broadcast clear) are looped straight into the RX FIFO
// instead of being offered to the router.
module node_port #(
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic        Clk_R,
    input  logic        Rst_n,
    input  logic [3:0]  r_addr,
    input  logic [28:0] core_tx_data,
    input  logic        core_tx_push,
    output logic        core_tx_full,
    node_port_if.master link,
    output logic [23:0] core_rx_data,
    output logic        core_rx_valid,
    input  logic        core_rx_pop,
    output logic        rx_overflow,
    output logic        ack_timeout,
    output logic [7:0]  rx_drop_count
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
    localparam logic [9:0]     TMO_LIMIT   = 10'(ACK_TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_GAP} state_t;

    // ---------------- TX FIFO ----------------
    logic [28:0]      tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [TX_AW:0]   tx_count_reg;
    logic             tx_push, tx_pop, tx_empty;
    logic [28:0]      tx_head;

    assign core_tx_full = (tx_count_reg == TX_FULL_CNT);
    assign tx_empty     = (tx_count_reg == '0);
    assign tx_head      = tx_mem[tx_rd_ptr_reg];
    assign tx_push      = core_tx_push && !core_tx_full;

    // TX storage write; contents need no reset because occupancy guards every read
    always_ff @(posedge Clk_R) begin
        if (tx_push) tx_mem[tx_wr_ptr_reg] <= core_tx_data;
    end

    // TX pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge Clk_R) begin
        if (!Rst_n) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count_reg <= tx_count_reg + (TX_AW+1)'(1);
                2'b01:   tx_count_reg <= tx_count_reg - (TX_AW+1)'(1);
                default: tx_count_reg <= tx_count_reg;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [23:0]      rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [RX_AW:0]   rx_count_reg;
    logic             rx_full, rx_empty;
    logic             rx_wr_en, rx_pop, rx_drop;
    logic [23:0]      rx_wr_data;
    logic             rx_overflow_reg;
    logic [7:0]       rx_drop_count_reg;

    assign rx_full       = (rx_count_reg == RX_FULL_CNT);
    assign rx_empty      = (rx_count_reg == '0);
    assign core_rx_valid = !rx_empty;
    assign core_rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr_reg];
    assign rx_overflow   = rx_overflow_reg;
    assign rx_drop_count = rx_drop_count_reg;

    // ---------------- Loopback decision ----------------
    logic loop_hit, loop_ok, loop_take;

`ifdef NODE_PORT_SELF_LOOP_EN
    assign loop_hit = !tx_empty && (tx_head[28:25] == r_addr) && !tx_head[24];
`else
    logic unused_r_addr;
    assign unused_r_addr = ^r_addr;
    assign loop_hit      = 1'b0;
`endif
    // Router deliveries win the RX write port; loopback also never overflows
    assign loop_ok = !rx_full && !link.Packet_To_Node_Valid;

    // RX write source select: router delivery first, then loopback; drop on full without pop
    always_comb begin
        rx_wr_en   = 1'b0;
        rx_wr_data = '0;
        rx_drop    = 1'b0;
        rx_pop     = core_rx_pop && !rx_empty;
        if (link.Packet_To_Node_Valid) begin
            if (!rx_full || core_rx_pop) begin
                rx_wr_en   = 1'b1;
                rx_wr_data = link.Packet_To_Node;
            end else begin
                rx_drop = 1'b1;
            end
        end else if (loop_take) begin
            rx_wr_en   = 1'b1;
            rx_wr_data = tx_head[23:0];
        end
    end

    // RX storage write; when full with a pop, the freed head slot is the write slot
    always_ff @(posedge Clk_R) begin
        if (rx_wr_en) rx_mem[rx_wr_ptr_reg] <= rx_wr_data;
    end

    // RX pointers, occupancy, sticky overflow and saturating drop counter
    always_ff @(posedge Clk_R) begin
        if (!Rst_n) begin
            rx_wr_ptr_reg     <= '0;
            rx_rd_ptr_reg     <= '0;
            rx_count_reg      <= '0;
            rx_overflow_reg   <= 1'b0;
            rx_drop_count_reg <= '0;
        end else begin
            if (rx_wr_en) rx_wr_ptr_reg <= rx_wr_ptr_reg + RX_AW'(1);
            if (rx_pop)   rx_rd_ptr_reg <= rx_rd_ptr_reg + RX_AW'(1);
            case ({rx_wr_en, rx_pop})
                2'b10:   rx_count_reg <= rx_count_reg + (RX_AW+1)'(1);
                2'b01:   rx_count_reg <= rx_count_reg - (RX_AW+1)'(1);
                default: rx_count_reg <= rx_count_reg;
            endcase
            if (rx_drop) begin
                rx_overflow_reg <= 1'b1;
                if (rx_drop_count_reg != 8'hFF)
                    rx_drop_count_reg <= rx_drop_count_reg + 8'd1;
            end
        end
    end

    // ---------------- TX offer FSM ----------------
    state_t      state_reg, state_next;
    logic [28:0] offer_reg;
    logic [9:0]  tmo_cnt_reg;
    logic [9:0]  tmo_cnt_inc;
    logic        ack_timeout_reg;
    logic        load_offer;
    logic        offer_wait;

    assign link.Packet_From_Node       = offer_reg;
    assign link.Packet_From_Node_Valid = (state_reg == ST_OFFER);
    assign ack_timeout                 = ack_timeout_reg;
    assign offer_wait                  = (state_reg == ST_OFFER) && !link.Core_Load_Ack;
    assign tmo_cnt_inc                 = tmo_cnt_reg + 10'd1;

    // State register plus offered packet and ack timeout tracking
    always_ff @(posedge Clk_R) begin
        if (!Rst_n) begin
            state_reg       <= ST_IDLE;
            offer_reg       <= '0;
            tmo_cnt_reg     <= '0;
            ack_timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_offer) begin
                offer_reg   <= tx_head;
                tmo_cnt_reg <= '0;
            end else if (offer_wait && (tmo_cnt_reg != 10'h3FF)) begin
                tmo_cnt_reg <= tmo_cnt_inc;
                if (tmo_cnt_inc == TMO_LIMIT) ack_timeout_reg <= 1'b1;
            end
        end
    end

    // Next-state: IDLE/GAP start an offer when a routable head exists; OFFER leaves on ack
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE, ST_GAP: state_next = (!tx_empty && !loop_hit) ? ST_OFFER : ST_IDLE;
            ST_OFFER:        state_next = link.Core_Load_Ack ? ST_GAP : ST_OFFER;
            default:         state_next = ST_IDLE;
        endcase
    end

    // Outputs: load the offer register, pop on ack, or consume a looped-back head
    always_comb begin
        load_offer = 1'b0;
        tx_pop     = 1'b0;
        loop_take  = 1'b0;
        unique case (state_reg)
            ST_IDLE, ST_GAP: begin
                if (!tx_empty) begin
                    if (loop_hit) begin
                        if (loop_ok) begin
                            tx_pop    = 1'b1;
                            loop_take = 1'b1;
                        end
                    end else begin
                        load_offer = 1'b1;
                    end
                end
            end
            ST_OFFER: tx_pop = link.Core_Load_Ack;
            default: ;
        endcase
    end

endmodule
